// File: rtl/btb_predictor_pkg.sv
// Shared types for the branch target buffer: control structs, counter views
// and the legacy single-entry branch record.
package btb_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } BTB_Cnt_Enum;

    typedef struct packed {
        logic upd_valid;
        logic upd_taken;
    } BTB_upd_ctrl;

    typedef struct packed {
        logic stall;
        logic flush;
    } HAZARD_ctrl_i;

    // Legacy single-entry 1-bit record; kept for older pipeline stages.
    typedef struct packed {
        logic        valid;
        logic [5:0]  tag;
        logic [31:0] target;
        logic        t;
    } CACHE_BRANCH;

    function automatic BTB_Cnt_Enum btb_cnt_view(input logic [1:0] cnt);
        return BTB_Cnt_Enum'(cnt);
    endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Up/down saturating counter with a load port; load wins over inc, inc over dec.
module sat_counter #(
    parameter int            W       = 2,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            if (cnt != {W{1'b1}}) cnt <= cnt + W'(1);
        end else if (dec) begin
            if (cnt != '0) cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, a zero-latency lookup port and a single-cycle update port.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 6,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   lk_pc,
    input  logic              lk_valid,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [XLEN-1:0]   lk_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              inv,
    output logic [STAT_W-1:0] hit_count
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));

    logic             v   [DEPTH];
    logic [TAG_W-1:0] tag [DEPTH];
    logic [XLEN-1:0]  ta  [DEPTH];
    logic [CNT_W-1:0] cnt [DEPTH];

    logic [INDEX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag;
    logic               upd_hit;
    BTB_upd_ctrl        upd_ctrl;

    assign lk_idx  = lk_pc[INDEX_W+1:2];
    assign lk_tag  = lk_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign upd_idx = upd_pc[INDEX_W+1:2];
    assign upd_tag = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];

    // Update port is valid-only: every upd_valid cycle is accepted, no ready.
    // inv suppresses a same-cycle update.
    assign upd_ctrl.upd_valid = upd_valid && !inv;
    assign upd_ctrl.upd_taken = upd_taken;

    // Lookup reads pre-update state; no bypass from a same-cycle update.
    assign lk_hit    = v[lk_idx] && (tag[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && cnt[lk_idx][CNT_W-1];
    assign lk_target = lk_hit ? ta[lk_idx] : '0;
    assign upd_hit   = v[upd_idx] && (tag[upd_idx] == upd_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i]   <= 1'b0;
                tag[i] <= '0;
                ta[i]  <= '0;
            end
        end else if (inv) begin
            for (int i = 0; i < DEPTH; i++) v[i] <= 1'b0;
        end else if (upd_ctrl.upd_valid && upd_ctrl.upd_taken) begin
            // Taken outcome either refreshes a hit or allocates over a miss.
            v[upd_idx]   <= 1'b1;
            tag[upd_idx] <= upd_tag;
            ta[upd_idx]  <= upd_target;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
        logic sel;
        assign sel = upd_ctrl.upd_valid && (upd_idx == INDEX_W'(i));

        sat_counter #(
            .W       (CNT_W),
            .RST_VAL (CNT_WNT)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (sel && upd_hit && upd_ctrl.upd_taken),
            .dec      (sel && upd_hit && !upd_ctrl.upd_taken),
            .load     (sel && !upd_hit && upd_ctrl.upd_taken),
            .load_val (CNT_WT),
            .cnt      (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
        end else if (lk_valid && lk_hit && (hit_count != {STAT_W{1'b1}})) begin
            hit_count <= hit_count + STAT_W'(1);
        end
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with saturating-counter direction prediction for the RISC-V Lite pipeline.
- Successor to the single-entry 1-bit `CACHE_BRANCH` record: adds configurable depth, tag width and counter width, allocation/update rules, global invalidate and a hit counter.
- IF stage uses the combinational lookup port to steer the next PC. EX/MEM stage writes resolved branch outcomes through the update port.

Parameters:
- XLEN, 32, PC and target width.
- INDEX_W, 6, log2 of entry count (64 entries, direct-mapped).
- TAG_W, 6, tag bits stored per entry. Constraint: INDEX_W+TAG_W+2 <= XLEN.
- CNT_W, 2, direction counter width; 1 reproduces legacy T-bit behaviour; legal 1..3.
- STAT_W, 32, hit-counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- lk_pc  in  XLEN  IF-stage PC to look up.
- lk_hit  out  1  valid entry with matching tag.
- lk_taken  out  1  lk_hit & counter MSB.
- lk_target  out  XLEN  stored target; 0 when !lk_hit.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target (meaningful when upd_taken).
- inv  in  1  invalidate all entries (fence / context switch).
- hit_count  out  STAT_W  saturating count of lookups with lk_hit=1 and lk_valid=1.
- lk_valid  in  1  qualifies lk_pc for statistics only; lookup outputs ignore it.

Behaviour:
- Address split: pc[1:0] ignored; index = pc[INDEX_W+1:2]; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
- Storage per entry: V, TAG[TAG_W], TA[XLEN], CNT[CNT_W]. Register-based, with a combinational read.
- Lookup is zero latency. Outputs are a pure function of lk_pc and current registered state.
- Same-cycle update to the same index is not bypassed; the lookup returns pre-update contents.
- Update (upd_valid=1), committed at next clk edge:
  - Hit, taken: CNT saturating +1 (max 2^CNT_W-1); TA <= upd_target.
  - Hit, not taken: CNT saturating -1 (min 0); TA unchanged.
  - Miss, taken: allocate/overwrite. V=1, TAG=upd tag, TA=upd_target, CNT = weakly-taken = 2^(CNT_W-1).
  - Miss, not taken: no state change. No allocation of never-taken branches.
- inv=1: all V cleared at next edge; CNT and TA untouched. inv takes precedence over a simultaneous upd_valid (the update is dropped).
- hit_count increments by 1 per cycle with lk_valid & lk_hit. It saturates at all-ones with no wrap, and is cleared only by rst; inv does not clear it.
- Reset (rst=1 at edge), including mid-operation:
  - All V=0; all CNT = weakly-not-taken = 2^(CNT_W-1)-1, which is 0 for CNT_W=1.
  - TA and TAG reset to 0; hit_count=0.
  - Any concurrent update or inv is ignored.
  - Next cycle: lk_hit=0, lk_taken=0, lk_target=0.
- CNT_W=1 is the legacy mode: allocate sets T=1, a not-taken hit clears T, a taken hit sets T.
- No state machine beyond per-entry counters. All writes are single-cycle with no backpressure; upd is always accepted.

Decomposition:
- Shared package gets:
  - a counter-direction enum `BTB_Cnt_Enum` {SNT, WNT, WT, ST} for CNT_W=2 debug views.
  - a `BTB_upd_ctrl` packed struct (upd_valid, upd_taken) alongside `HAZARD_ctrl_i`.
- The legacy `CACHE_BRANCH` struct stays for compatibility; entry storage in this block is sized by parameters, not by that struct.
- One natural sub-module: `sat_counter`, parametrised by width, with inc/dec/load inputs and saturation at both ends. Instantiated per entry via generate.

Test Plan (XLEN=32, INDEX_W=6, TAG_W=6, CNT_W=2):
- Reset then lk_pc=0x0000_0100 -> lk_hit=0, lk_taken=0, lk_target=0, hit_count=0.
- upd pc=0x100, taken, target=0x200; next cycle lk_pc=0x100 -> lk_hit=1, lk_taken=1 (CNT=2), lk_target=0x200.
- Two further not-taken updates to 0x100 -> CNT 2→1→0; lk_taken=0, lk_hit=1. Third not-taken leaves CNT=0. A taken update then gives CNT=1, lk_taken=0.
- Aliasing: entry for 0x100 valid, then taken update for pc=0x1100 (same index, tag differs) -> 0x1100 hits with its target; lk_pc=0x100 now misses.
- Same cycle inv=1 and upd_valid=1 (taken, pc=0x300) -> next cycle all lookups miss, including 0x300. hit_count is unchanged by inv.
- hit_count forced near saturation (STAT_W=4 build): 16 consecutive valid hits -> holds at 4'hF. Reset asserted mid-sequence -> 0 next cycle and all entries miss.
